calc_eval_ctrl: RTL and testbench

- Sequencer between the calculator front panel (switches, buttons) and the data-memory calculator port.
- On EVALUATE: validates the operands, issues the one-cycle store into RAM[0]/RAM[1]/RAM[7], then waits for the ARM program's completion pulse.
- On completion: selects the result word for the requested op and holds it for the display, with busy, error and timeout status.
- Sits between the board I/O debouncers and dmem; the ARM core runs unchanged.

---
 rtl/calc_eval_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_calc_eval_ctrl.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_eval_ctrl.sv
// calc_eval_ctrl: front-panel EVALUATE/CLEAR sequencer for the dmem calculator port; store strobe 1 cycle after the eval edge, result held 2 cycles after cpu_done.
// No backpressure: eval edges while busy are dropped, not queued; WAIT timeout exists only when CALC_TIMEOUT_EN is defined.
module calc_eval_ctrl #(
    parameter int DATA_W      = 32,
    parameter int OP_W        = 3,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              eval_btn,
    input  logic              clear_btn,
    input  logic [DATA_W-1:0] sw_a,
    input  logic [DATA_W-1:0] sw_b,
    input  logic [OP_W-1:0]   sw_op,
    input  logic              cpu_done,
    input  logic [DATA_W-1:0] result_suma,
    input  logic [DATA_W-1:0] result_resta,
    input  logic [DATA_W-1:0] result_mult,
    input  logic [DATA_W-1:0] result_div,
    input  logic [DATA_W-1:0] result_pow,
    output logic              calc_store_en,
    output logic [DATA_W-1:0] calc_a,
    output logic [DATA_W-1:0] calc_b,
    output logic [OP_W-1:0]   calc_op,
    output logic              reset_en,
    output logic [DATA_W-1:0] disp_result,
    output logic              disp_valid,
    output logic              busy,
    output logic              err_div0,
    output logic              err_op,
    output logic              err_timeout
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_STORE = 3'd1,
        S_WAIT  = 3'd2,
        S_CAPT  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > (1 << 20)) begin : g_bad_timeout
        $error("calc_eval_ctrl: TIMEOUT_CYC must be in 1..2^20");
    end

    state_t            state, state_nxt;
    logic              eval_prev, clear_prev;
    logic              eval_edge, clear_edge;
    logic              op_bad, div_zero;
    logic              do_check, accept;
    logic              timeout_hit;
    logic [DATA_W-1:0] result_sel;

    assign eval_edge  = eval_btn & ~eval_prev;
    assign clear_edge = clear_btn & ~clear_prev;
    assign op_bad     = sw_op > OP_W'(4);
    assign div_zero   = (sw_op == OP_W'(3)) && (sw_b == '0);
    // ERR re-runs the operand checks directly, same as IDLE; clear always takes priority.
    assign do_check   = eval_edge && !clear_edge && (state == S_IDLE || state == S_ERR);
    assign accept     = do_check && !op_bad && !div_zero;

    assign calc_store_en = (state == S_STORE);
    assign busy          = (state == S_STORE) || (state == S_WAIT) || (state == S_CAPT);

`ifdef CALC_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [CNT_W-1:0] wait_cnt;

    assign timeout_hit = (state == S_WAIT) && !cpu_done &&
                         (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt    <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (state == S_STORE)
                wait_cnt <= '0;
            else if (state == S_WAIT)
                wait_cnt <= wait_cnt + CNT_W'(1);

            if (clear_edge || do_check)
                err_timeout <= 1'b0;
            else if (timeout_hit)
                err_timeout <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_comb begin
        result_sel = '0;
        case (calc_op)
            OP_W'(0): result_sel = result_suma;
            OP_W'(1): result_sel = result_resta;
            OP_W'(2): result_sel = result_mult;
            OP_W'(3): result_sel = result_div;
            OP_W'(4): result_sel = result_pow;
            default:  result_sel = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        if (clear_edge) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_ERR: begin
                    if (eval_edge)
                        state_nxt = (op_bad || div_zero) ? S_ERR : S_STORE;
                end
                S_STORE: state_nxt = S_WAIT;
                S_WAIT: begin
                    if (cpu_done)
                        state_nxt = S_CAPT;
                    else if (timeout_hit)
                        state_nxt = S_ERR;
                end
                S_CAPT:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            eval_prev  <= 1'b0;
            clear_prev <= 1'b0;
        end else begin
            state      <= state_nxt;
            eval_prev  <= eval_btn;
            clear_prev <= clear_btn;
        end
    end

    // reset_en lands in the cycle after the clear edge, when the FSM is already
    // in IDLE, so it can never coincide with the STORE-cycle strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reset_en    <= 1'b0;
            calc_a      <= '0;
            calc_b      <= '0;
            calc_op     <= '0;
            disp_result <= '0;
            disp_valid  <= 1'b0;
            err_div0    <= 1'b0;
            err_op      <= 1'b0;
        end else begin
            reset_en <= clear_edge;
            if (clear_edge) begin
                calc_a      <= '0;
                calc_b      <= '0;
                calc_op     <= '0;
                disp_result <= '0;
                disp_valid  <= 1'b0;
                err_div0    <= 1'b0;
                err_op      <= 1'b0;
            end else begin
                if (do_check) begin
                    err_op     <= op_bad;
                    err_div0   <= !op_bad && div_zero;
                    disp_valid <= 1'b0;
                end
                if (accept) begin
                    calc_a  <= sw_a;
                    calc_b  <= sw_b;
                    calc_op <= sw_op;
                end
                if (state == S_CAPT) begin
                    disp_result <= result_sel;
                    disp_valid  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_calc_eval_ctrl.sv
module tb_calc_eval_ctrl;
    localparam int DW = 32;
    localparam int OW = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          eval_btn, clear_btn, cpu_done;
    logic [DW-1:0] sw_a, sw_b;
    logic [OW-1:0] sw_op;
    logic [DW-1:0] result_suma, result_resta, result_mult, result_div, result_pow;
    logic          calc_store_en, reset_en, disp_valid, busy;
    logic          err_div0, err_op, err_timeout;
    logic [DW-1:0] calc_a, calc_b, disp_result;
    logic [OW-1:0] calc_op;

    int checks = 0;
    int errors = 0;
    int store_cnt = 0;
    int rst_cnt = 0;
    int overlap_cnt = 0;

    calc_eval_ctrl #(.DATA_W(DW), .OP_W(OW), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .reset_n(reset_n), .eval_btn(eval_btn), .clear_btn(clear_btn),
        .sw_a(sw_a), .sw_b(sw_b), .sw_op(sw_op), .cpu_done(cpu_done),
        .result_suma(result_suma), .result_resta(result_resta), .result_mult(result_mult),
        .result_div(result_div), .result_pow(result_pow),
        .calc_store_en(calc_store_en), .calc_a(calc_a), .calc_b(calc_b), .calc_op(calc_op),
        .reset_en(reset_en), .disp_result(disp_result), .disp_valid(disp_valid), .busy(busy),
        .err_div0(err_div0), .err_op(err_op), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (calc_store_en) store_cnt++;
        if (reset_en) rst_cnt++;
        if (calc_store_en && reset_en) overlap_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // Reference arithmetic the "ARM program" would compute.
    function automatic logic [DW-1:0] calc_model(input int op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] p;
        case (op)
            0: return a + b;
            1: return a - b;
            2: return a * b;
            3: return (b == 0) ? '0 : a / b;
            4: begin
                p = 1;
                for (int i = 0; i < int'(b); i++) p = p * a;
                return p;
            end
            default: return '0;
        endcase
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_sw(input logic [DW-1:0] a, input logic [DW-1:0] b, input int op);
        sw_a = a;
        sw_b = b;
        sw_op = OW'(op);
        result_suma  = calc_model(0, a, b);
        result_resta = calc_model(1, a, b);
        result_mult  = calc_model(2, a, b);
        result_div   = calc_model(3, a, b);
        result_pow   = calc_model(4, a, b);
    endtask

    task automatic press_eval();
        eval_btn = 1'b1;
        tick();
        eval_btn = 1'b0;
    endtask

    task automatic press_clear();
        clear_btn = 1'b1;
        tick();
        clear_btn = 1'b0;
    endtask

    task automatic pulse_done();
        cpu_done = 1'b1;
        tick();
        cpu_done = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        eval_btn = 0; clear_btn = 0; cpu_done = 0;
        set_sw(0, 0, 0);
        tick(3);
        checks++;
        if ({calc_store_en, reset_en, disp_valid, busy, err_div0, err_op, err_timeout} !== 7'b0 ||
            calc_a !== 0 || calc_b !== 0 || calc_op !== 0 || disp_result !== 0) begin
            errors++;
            $display("FAIL reset_outputs: got store=%0b rst=%0b valid=%0b busy=%0b errs=%0b%0b%0b a=%0h b=%0h op=%0d disp=%0h, expected all 0",
                     calc_store_en, reset_en, disp_valid, busy, err_div0, err_op, err_timeout, calc_a, calc_b, calc_op, disp_result);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_add();
        set_sw(10, 5, 0);
        press_eval();
        checks++;
        if (calc_store_en !== 1'b1 || busy !== 1'b1 || calc_a !== 10 || calc_b !== 5) begin
            errors++;
            $display("FAIL add_store: got store=%0b busy=%0b a=%0d b=%0d, expected 1 1 10 5", calc_store_en, busy, calc_a, calc_b);
        end
        tick(10);
        checks++;
        if (calc_store_en !== 1'b0 || busy !== 1'b1 || disp_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_wait: got store=%0b busy=%0b valid=%0b, expected 0 1 0", calc_store_en, busy, disp_valid);
        end
        pulse_done();
        checks++;
        if (busy !== 1'b1 || disp_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_capt: got busy=%0b valid=%0b, expected 1 0", busy, disp_valid);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || disp_valid !== 1'b1 || disp_result !== 15) begin
            errors++;
            $display("FAIL add_result: got busy=%0b valid=%0b disp=%0d, expected 0 1 15", busy, disp_valid, disp_result);
        end
    endtask

    task automatic test_div0();
        int s0;
        s0 = store_cnt;
        set_sw(8, 0, 3);
        press_eval();
        tick();
        checks++;
        if (err_div0 !== 1'b1 || err_op !== 1'b0 || busy !== 1'b0 || disp_valid !== 1'b0 || store_cnt != s0) begin
            errors++;
            $display("FAIL div0_err: got div0=%0b op=%0b busy=%0b valid=%0b stores=%0d, expected 1 0 0 0 0",
                     err_div0, err_op, busy, disp_valid, store_cnt - s0);
        end
        set_sw(8, 2, 3);
        press_eval();
        checks++;
        if (err_div0 !== 1'b0 || calc_store_en !== 1'b1) begin
            errors++;
            $display("FAIL div0_retry: got div0=%0b store=%0b, expected 0 1", err_div0, calc_store_en);
        end
        tick(3);
        pulse_done();
        tick();
        checks++;
        if (disp_result !== 4 || disp_valid !== 1'b1) begin
            errors++;
            $display("FAIL div0_result: got disp=%0d valid=%0b, expected 4 1", disp_result, disp_valid);
        end
    endtask

    task automatic test_illegal_op_stale();
        int s0;
        s0 = store_cnt;
        set_sw(3, 4, 6);
        press_eval();
        tick();
        checks++;
        if (err_op !== 1'b1 || busy !== 1'b0 || store_cnt != s0) begin
            errors++;
            $display("FAIL illegal_op: got err_op=%0b busy=%0b stores=%0d, expected 1 0 0", err_op, busy, store_cnt - s0);
        end
        press_clear();
        tick();
        pulse_done();
        tick();
        checks++;
        if (busy !== 1'b0 || disp_valid !== 1'b0 || err_op !== 1'b0 || store_cnt != s0) begin
            errors++;
            $display("FAIL stale_idle: got busy=%0b valid=%0b err_op=%0b stores=%0d, expected 0 0 0 0",
                     busy, disp_valid, err_op, store_cnt - s0);
        end
        set_sw(7, 3, 1);
        press_eval();
        cpu_done = 1'b1;
        tick();
        cpu_done = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b1 || disp_valid !== 1'b0) begin
            errors++;
            $display("FAIL stale_store: got busy=%0b valid=%0b, expected 1 0", busy, disp_valid);
        end
        pulse_done();
        tick();
        checks++;
        if (disp_result !== 4 || disp_valid !== 1'b1) begin
            errors++;
            $display("FAIL stale_result: got disp=%0d valid=%0b, expected 4 1", disp_result, disp_valid);
        end
    endtask

    task automatic test_timeout();
        set_sw(2, 3, 2);
        press_eval();
        tick();
`ifdef CALC_TIMEOUT_EN
        tick(15);
        checks++;
        if (err_timeout !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early: got err_timeout=%0b busy=%0b at WAIT cycle 16, expected 0 1", err_timeout, busy);
        end
        tick();
        checks++;
        if (err_timeout !== 1'b1 || busy !== 1'b0 || disp_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_hit: got err_timeout=%0b busy=%0b valid=%0b, expected 1 0 0", err_timeout, busy, disp_valid);
        end
        pulse_done();
        set_sw(2, 3, 2);
        press_eval();
        checks++;
        if (err_timeout !== 1'b0 || calc_store_en !== 1'b1) begin
            errors++;
            $display("FAIL timeout_retry: got err_timeout=%0b store=%0b, expected 0 1", err_timeout, calc_store_en);
        end
        tick();
`else
        tick(100);
        checks++;
        if (busy !== 1'b1 || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL no_timeout: got busy=%0b err_timeout=%0b after 100 WAIT cycles, expected 1 0", busy, err_timeout);
        end
`endif
        pulse_done();
        tick();
        checks++;
        if (disp_result !== 6 || disp_valid !== 1'b1) begin
            errors++;
            $display("FAIL timeout_result: got disp=%0d valid=%0b, expected 6 1", disp_result, disp_valid);
        end
    endtask

    task automatic test_clear_vs_eval();
        int s0, r0;
        set_sw(100, 7, 2);
        press_eval();
        s0 = store_cnt;
        r0 = rst_cnt;
        tick(4);
        set_sw(1, 1, 0);
        eval_btn = 1'b1;
        clear_btn = 1'b1;
        tick();
        checks++;
        if (reset_en !== 1'b1 || calc_store_en !== 1'b0 || busy !== 1'b0 ||
            calc_a !== 0 || calc_b !== 0 || calc_op !== 0 || disp_result !== 0) begin
            errors++;
            $display("FAIL clear_eval: got rst=%0b store=%0b busy=%0b a=%0d b=%0d op=%0d disp=%0d, expected 1 0 0 0 0 0 0",
                     reset_en, calc_store_en, busy, calc_a, calc_b, calc_op, disp_result);
        end
        tick();
        eval_btn = 1'b0;
        clear_btn = 1'b0;
        checks++;
        if (reset_en !== 1'b0 || calc_store_en !== 1'b0) begin
            errors++;
            $display("FAIL clear_once: got rst=%0b store=%0b, expected 0 0", reset_en, calc_store_en);
        end
        tick(2);
        pulse_done();
        tick(2);
        checks++;
        if (disp_valid !== 1'b0 || busy !== 1'b0 || rst_cnt - r0 != 1 || store_cnt - s0 != 1) begin
            errors++;
            $display("FAIL clear_late_done: got valid=%0b busy=%0b resets=%0d stores=%0d, expected 0 0 1 1",
                     disp_valid, busy, rst_cnt - r0, store_cnt - s0);
        end
    endtask

    task automatic test_busy_lockout();
        int s0;
        s0 = store_cnt;
        set_sw(50, 20, 1);
        press_eval();
        tick(3);
        sw_a = 999;
        sw_b = 111;
        sw_op = 3'd2;
        press_eval();
        tick(2);
        checks++;
        if (calc_a !== 50 || calc_b !== 20 || calc_op !== 1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL lockout_latch: got a=%0d b=%0d op=%0d busy=%0b, expected 50 20 1 1", calc_a, calc_b, calc_op, busy);
        end
        pulse_done();
        tick(3);
        checks++;
        if (disp_result !== 30 || disp_valid !== 1'b1 || store_cnt - s0 != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL lockout_result: got disp=%0d valid=%0b stores=%0d busy=%0b, expected 30 1 1 0",
                     disp_result, disp_valid, store_cnt - s0, busy);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] a, b, exp_res;
        int op, lat, s0;
        for (int n = 0; n < 30; n++) begin
            a = $urandom();
            b = DW'($urandom_range(0, 9));
            op = $urandom_range(0, 7);
            lat = $urandom_range(0, 10);
            set_sw(a, b, op);
            s0 = store_cnt;
            press_eval();
            if (op > 4 || (op == 3 && b == 0)) begin
                tick();
                checks++;
                if (err_op !== (op > 4) || err_div0 !== (op <= 4) || busy !== 1'b0 || store_cnt != s0) begin
                    errors++;
                    $display("FAIL rand_err[%0d]: op=%0d b=%0d got err_op=%0b err_div0=%0b busy=%0b stores=%0d",
                             n, op, b, err_op, err_div0, busy, store_cnt - s0);
                end
                press_clear();
                tick();
            end else begin
                exp_res = calc_model(op, a, b);
                tick(1 + lat);
                pulse_done();
                tick();
                checks++;
                if (disp_result !== exp_res || disp_valid !== 1'b1 || store_cnt - s0 != 1 ||
                    calc_a !== a || calc_b !== b || calc_op !== OW'(op)) begin
                    errors++;
                    $display("FAIL rand_res[%0d]: op=%0d a=%0h b=%0d got disp=%0h valid=%0b stores=%0d, expected disp=%0h valid=1 stores=1",
                             n, op, a, b, disp_result, disp_valid, store_cnt - s0, exp_res);
                end
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        int s0, r0;
        set_sw(4, 4, 0);
        press_eval();
        tick(3);
        s0 = store_cnt;
        r0 = rst_cnt;
        reset_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || calc_store_en !== 1'b0 || reset_en !== 1'b0 || calc_a !== 0 || disp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_wait: got busy=%0b store=%0b rst=%0b a=%0d valid=%0b, expected all 0",
                     busy, calc_store_en, reset_en, calc_a, disp_valid);
        end
        tick(2);
        reset_n = 1'b1;
        tick(3);
        checks++;
        if (store_cnt != s0 || rst_cnt != r0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes: got stores=%0d resets=%0d busy=%0b, expected 0 0 0", store_cnt - s0, rst_cnt - r0, busy);
        end
    endtask

    task automatic test_strobe_overlap();
        checks++;
        if (overlap_cnt != 0) begin
            errors++;
            $display("FAIL strobe_overlap: got %0d cycles with both strobes high, expected 0", overlap_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_div0();
        test_illegal_op_stale();
        test_timeout();
        test_clear_vs_eval();
        test_busy_lockout();
        test_random();
        test_reset_mid_wait();
        test_strobe_overlap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
